// File: rtl/lcd_bus_writer_if.sv
// rtl/lcd_bus_writer_if.sv - write-FIFO drain and 8080-style LCD write bus bundle
interface lcd_bus_writer_if;
  // FIFO side: show-ahead read port, {ID, data} words
  logic        fifo_empty;
  logic [16:0] fifo_rdata;
  logic        fifo_rd;
  // LCD side: 16-bit 8080 write bus
  logic        LCD_CS;
  logic        LCD_RS;
  logic        LCD_WR;
  logic        LCD_RD;
  logic [15:0] LCD_DATA;
  // status
  logic        busy;

  // The bus writer: consumes the FIFO, drives the LCD pins
  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_rd,
    output LCD_CS,
    output LCD_RS,
    output LCD_WR,
    output LCD_RD,
    output LCD_DATA,
    output busy
  );

  // The surroundings: FIFO supplying words, LCD/observer watching the pins
  modport slave (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_rd,
    input  LCD_CS,
    input  LCD_RS,
    input  LCD_WR,
    input  LCD_RD,
    input  LCD_DATA,
    input  busy
  );
endinterface

// File: rtl/lcd_bus_writer.sv
// rtl/lcd_bus_writer.sv - drains {ID,data} FIFO words onto an 8080 LCD write bus
module lcd_bus_writer #(
  parameter int unsigned T_SETUP = 1,  // WR-high cycles with RS/DATA/CS valid before WR falls (1..15)
  parameter int unsigned T_WRL   = 1,  // WR-low cycles (1..15)
  parameter int unsigned T_WRH   = 1,  // WR-high cycles after the rising edge, data held (1..15)
  parameter int unsigned CS_IDLE = 4   // empty-FIFO idle cycles before CS releases (0..15)
) (
  input  logic              clk,
  input  logic              rst_n,
  lcd_bus_writer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_WR_LOW  = 2'd2,
    S_WR_HIGH = 2'd3
  } state_e;

  // Last value of the phase counter in each timed phase
  localparam logic [3:0] SETUP_LAST   = 4'(T_SETUP - 1);
  localparam logic [3:0] WRL_LAST     = 4'(T_WRL - 1);
  localparam logic [3:0] WRH_LAST     = 4'(T_WRH - 1);
  localparam logic [3:0] CS_IDLE_LAST = 4'(CS_IDLE - 1);
  // CS_IDLE of zero releases CS on the WR_HIGH->IDLE edge instead of counting
  localparam bit         CS_IDLE_EN   = (CS_IDLE != 0);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idle_cnt_q, idle_cnt_d;
  logic        cs_q, cs_d;
  logic        rs_q, rs_d;
  logic        wr_q, wr_d;
  logic [15:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        pop;

  // A word is taken either from IDLE or at the very end of WR_HIGH, so the
  // next word's setup phase follows the previous strobe with no gap cycle
  always_comb begin
    pop = !bus.fifo_empty && rst_n &&
          ((state_q == S_IDLE) || ((state_q == S_WR_HIGH) && (cnt_q == WRH_LAST)));
  end

  // Next-state and next-pin computation; every pin register holds by default
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idle_cnt_d = idle_cnt_q;
    cs_d       = cs_q;
    rs_d       = rs_q;
    wr_d       = wr_q;
    data_d     = data_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          data_d     = bus.fifo_rdata[15:0];
          rs_d       = bus.fifo_rdata[16];
          cs_d       = 1'b0;
          wr_d       = 1'b1;
          state_d    = S_SETUP;
          cnt_d      = 4'd0;
          idle_cnt_d = 4'd0;
        end else begin
          idle_cnt_d = (idle_cnt_q == 4'hF) ? 4'hF : idle_cnt_q + 4'd1;
          if (CS_IDLE_EN && (idle_cnt_q == CS_IDLE_LAST)) begin
            cs_d = 1'b1;
          end
        end
      end

      S_SETUP: begin
        wr_d = 1'b1;
        if (cnt_q == SETUP_LAST) begin
          wr_d    = 1'b0;
          state_d = S_WR_LOW;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WR_LOW: begin
        wr_d = 1'b0;
        if (cnt_q == WRL_LAST) begin
          wr_d    = 1'b1;
          state_d = S_WR_HIGH;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WR_HIGH: begin
        wr_d = 1'b1;
        if (cnt_q == WRH_LAST) begin
          if (pop) begin
            // Back-to-back word: CS stays low, new data lands with WR high
            data_d     = bus.fifo_rdata[15:0];
            rs_d       = bus.fifo_rdata[16];
            cs_d       = 1'b0;
            state_d    = S_SETUP;
            cnt_d      = 4'd0;
            idle_cnt_d = 4'd0;
          end else begin
            state_d    = S_IDLE;
            cnt_d      = 4'd0;
            idle_cnt_d = 4'd0;
            if (!CS_IDLE_EN) begin
              cs_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        wr_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and pin registers; reset drops any word in flight and parks the bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      idle_cnt_q <= 4'd0;
      cs_q       <= 1'b1;
      rs_q       <= 1'b0;
      wr_q       <= 1'b1;
      data_q     <= 16'h0000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_cnt_q <= idle_cnt_d;
      cs_q       <= cs_d;
      rs_q       <= rs_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.fifo_rd  = pop;
  assign bus.LCD_CS   = cs_q;
  assign bus.LCD_RS   = rs_q;
  assign bus.LCD_WR   = wr_q;
  assign bus.LCD_RD   = 1'b1;
  assign bus.LCD_DATA = data_q;
  assign bus.busy     = busy_q;

  // A write strobe is only ever issued to a selected panel
  a_wr_needs_cs: assert property (@(posedge clk) !wr_q |-> !cs_q);

  // busy mirrors the registered state
  a_busy_state: assert property (@(posedge clk) busy_q == (state_q != S_IDLE));

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb/tb_lcd_bus_writer.sv - directed vector bench for lcd_bus_writer
module tb_lcd_bus_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_v [2];
  logic [16:0] mem     [2][64];
  int          wr_ptr  [2];
  wire [31:0]  pop_cnt [2];
  wire         fifo_rd_o [2];
  wire         cs_o      [2];
  wire         rs_o      [2];
  wire         wr_o      [2];
  wire         rd_o      [2];
  wire         busy_o    [2];
  wire [15:0]  data_o    [2];

  int checks   = 0;
  int failures = 0;

  // Instance 0: default timing. Instance 1: T_SETUP=2, T_WRL=3, T_WRH=2, CS_IDLE=0.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    lcd_bus_writer_if bus ();
    int rd_ptr = 0;

    always @(posedge clk) begin
      if (bus.fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    assign bus.fifo_empty = (rd_ptr == wr_ptr[g]);
    assign bus.fifo_rdata = mem[g][rd_ptr % 64];
    assign pop_cnt[g]     = rd_ptr;
    assign fifo_rd_o[g]   = bus.fifo_rd;
    assign cs_o[g]        = bus.LCD_CS;
    assign rs_o[g]        = bus.LCD_RS;
    assign wr_o[g]        = bus.LCD_WR;
    assign rd_o[g]        = bus.LCD_RD;
    assign busy_o[g]      = bus.busy;
    assign data_o[g]      = bus.LCD_DATA;

    lcd_bus_writer #(
      .T_SETUP ((g == 0) ? 1 : 2),
      .T_WRL   ((g == 0) ? 1 : 3),
      .T_WRH   ((g == 0) ? 1 : 2),
      .CS_IDLE ((g == 0) ? 4 : 0)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n_v[g]),
      .bus   (bus.master)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int g, input logic [16:0] w);
    mem[g][wr_ptr[g] % 64] = w;
    wr_ptr[g] = wr_ptr[g] + 1;
  endtask

  // exp_rd is sampled before the edge; the pin fields are sampled after it
  typedef struct packed {
    logic        rst;
    logic        push;
    logic [16:0] word;
    logic        exp_rd;
    logic        exp_cs;
    logic        exp_rs;
    logic        exp_wr;
    logic [15:0] exp_data;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [11];

  logic [15:0] sw [4];
  logic [15:0] tw [2];

  initial begin
    int wr_pulses;
    int gap;
    int max_gap;
    bit started;
    logic prev_wr;
    int pops_before;
    int ph;
    logic exp_wr;

    rst_n_v[0] = 1'b0;
    rst_n_v[1] = 1'b0;
    wr_ptr[0]  = 0;
    wr_ptr[1]  = 0;

    // Reset, then a single instruction word with default timing
    vecs[0]  = '{1'b0, 1'b0, 17'h0,        1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 17'h0,        1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 17'h0_002A,   1'b1, 1'b0, 1'b0, 1'b1, 16'h002A, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 17'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h002A, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 17'h0,        1'b0, 1'b0, 1'b0, 1'b1, 16'h002A, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 17'h0,        1'b0, 1'b0, 1'b0, 1'b1, 16'h002A, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 17'h0,        1'b0, 1'b0, 1'b0, 1'b1, 16'h002A, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 17'h0,        1'b0, 1'b0, 1'b0, 1'b1, 16'h002A, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 17'h0,        1'b0, 1'b0, 1'b0, 1'b1, 16'h002A, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 17'h0,        1'b0, 1'b1, 1'b0, 1'b1, 16'h002A, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 17'h0,        1'b0, 1'b1, 1'b0, 1'b1, 16'h002A, 1'b0};

    sw[0] = 16'h0000; sw[1] = 16'h1111; sw[2] = 16'h2222; sw[3] = 16'h3333;
    tw[0] = 16'hA5C3; tw[1] = 16'h0F0F;

    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      rst_n_v[0] = vecs[i].rst;
      rst_n_v[1] = vecs[i].rst;
      if (vecs[i].push) push(0, vecs[i].word);
      #1;
      chk($sformatf("vec%0d_fifo_rd", i), fifo_rd_o[0], vecs[i].exp_rd);
      tick();
      chk($sformatf("vec%0d_cs", i),   cs_o[0],   vecs[i].exp_cs);
      chk($sformatf("vec%0d_rs", i),   rs_o[0],   vecs[i].exp_rs);
      chk($sformatf("vec%0d_wr", i),   wr_o[0],   vecs[i].exp_wr);
      chk($sformatf("vec%0d_data", i), data_o[0], vecs[i].exp_data);
      chk($sformatf("vec%0d_busy", i), busy_o[0], vecs[i].exp_busy);
      chk($sformatf("vec%0d_rd", i),   rd_o[0],   1'b1);
    end

    // Back-to-back stream of four data words queued before the start
    for (int i = 0; i < 4; i++) push(0, {1'b1, sw[i]});
    wr_pulses = 0; gap = 0; max_gap = 0; started = 1'b0; prev_wr = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk($sformatf("stream%0d_fifo_rd", k), fifo_rd_o[0], (k % 3) == 0);
      tick();
      chk($sformatf("stream%0d_cs", k), cs_o[0], 1'b0);
      chk($sformatf("stream%0d_rs", k), rs_o[0], 1'b1);
      chk($sformatf("stream%0d_wr", k), wr_o[0], (k % 3) != 1);
      if ((k % 3) == 1) chk($sformatf("stream%0d_data", k), data_o[0], sw[k / 3]);
      if (wr_o[0] == 1'b0) begin
        if (prev_wr) wr_pulses++;
        if (started && gap > max_gap) max_gap = gap;
        started = 1'b1;
        gap = 0;
      end else if (started) begin
        gap++;
      end
      prev_wr = wr_o[0];
    end
    chk("stream_wr_pulses", wr_pulses, 4);
    chk("stream_max_wr_high_gap", max_gap, 2);

    // New word arrives inside the CS idle window: CS must not release
    tick();
    chk("win_enter_idle_busy", busy_o[0], 1'b0);
    chk("win_idle0_cs", cs_o[0], 1'b0);
    tick();
    chk("win_idle1_cs", cs_o[0], 1'b0);
    tick();
    chk("win_idle2_cs", cs_o[0], 1'b0);
    push(0, {1'b0, 16'hBEEF});
    #1;
    chk("win_fifo_rd", fifo_rd_o[0], 1'b1);
    tick();
    chk("win_pop_cs", cs_o[0], 1'b0);
    chk("win_pop_data", data_o[0], 16'hBEEF);
    chk("win_pop_rs", rs_o[0], 1'b0);
    chk("win_pop_busy", busy_o[0], 1'b1);
    tick(); tick(); tick();
    chk("win_done_busy", busy_o[0], 1'b0);

    // Reset while WR is low: immediate abort, no further pops
    push(0, {1'b1, 16'h5A5A});
    #1;
    chk("rst_pop_fifo_rd", fifo_rd_o[0], 1'b1);
    tick();
    tick();
    chk("rst_pre_wr_low", wr_o[0], 1'b0);
    rst_n_v[0] = 1'b0;
    #1;
    chk("rst_fifo_rd_low", fifo_rd_o[0], 1'b0);
    tick();
    chk("rst_wr", wr_o[0], 1'b1);
    chk("rst_cs", cs_o[0], 1'b1);
    chk("rst_data", data_o[0], 16'h0000);
    chk("rst_rs", rs_o[0], 1'b0);
    chk("rst_busy", busy_o[0], 1'b0);
    pops_before = pop_cnt[0];
    rst_n_v[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("post_rst%0d_fifo_rd", k), fifo_rd_o[0], 1'b0);
      tick();
      chk($sformatf("post_rst%0d_cs", k), cs_o[0], 1'b1);
      chk($sformatf("post_rst%0d_busy", k), busy_o[0], 1'b0);
    end
    chk("post_rst_pop_count", pop_cnt[0], pops_before);

    // fifo_rd stays low under reset even with a word waiting
    rst_n_v[0] = 1'b0;
    push(0, {1'b0, 16'h1234});
    #1;
    chk("rst_gate_fifo_rd", fifo_rd_o[0], 1'b0);
    tick();
    rst_n_v[0] = 1'b1;
    #1;
    chk("rst_release_fifo_rd", fifo_rd_o[0], 1'b1);
    tick();
    chk("rst_release_data", data_o[0], 16'h1234);
    chk("rst_release_cs", cs_o[0], 1'b0);
    tick(); tick(); tick();
    chk("rst_release_done_busy", busy_o[0], 1'b0);

    // Slow timing (2/3/2, CS_IDLE=0): 7-cycle period, CS rises on the IDLE edge
    push(1, {1'b1, tw[0]});
    push(1, {1'b0, tw[1]});
    for (int k = 0; k < 15; k++) begin
      #1;
      chk($sformatf("slow%0d_fifo_rd", k), fifo_rd_o[1], (k == 0) || (k == 7));
      tick();
      if (k < 14) begin
        ph = k % 7;
        exp_wr = !((ph >= 2) && (ph <= 4));
        chk($sformatf("slow%0d_wr", k),   wr_o[1],   exp_wr);
        chk($sformatf("slow%0d_data", k), data_o[1], tw[k / 7]);
        chk($sformatf("slow%0d_rs", k),   rs_o[1],   k < 7);
        chk($sformatf("slow%0d_cs", k),   cs_o[1],   1'b0);
        chk($sformatf("slow%0d_busy", k), busy_o[1], 1'b1);
      end else begin
        chk("slow_idle_cs", cs_o[1], 1'b1);
        chk("slow_idle_busy", busy_o[1], 1'b0);
        chk("slow_idle_wr", wr_o[1], 1'b1);
        chk("slow_idle_data_hold", data_o[1], tw[1]);
      end
    end
    tick();
    chk("slow_idle_cs_stays", cs_o[1], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
